// File: rtl/fire9_squeeze_ofm_writer.sv
// Captures fire9 squeeze output vectors and serializes them into feature-map RAM.
// Latency: channel k of a vector sampled in cycle t is written in cycle t+1+k.
// Backpressure: none; samples arriving mid-write are dropped and flagged in overrun.
module fire9_squeeze_ofm_writer #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 112,
    parameter int WOUT   = 8,
    parameter int AW     = $clog2(WOUT**2*DSP_NO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_in,
    input  logic [WIDTH-1:0]          ofm_in [0:DSP_NO-1],
    input  logic                      layer_finish,
    input  logic                      clear,
    output logic                      ram_we,
    output logic [AW-1:0]             ram_addr,
    output logic [WIDTH-1:0]          ram_wdata,
    output logic                      ram_feedback,
    output logic                      done,
    output logic                      overrun,
    output logic [$clog2(WOUT**2):0]  pix_count
);

    localparam int PIX  = WOUT**2;
    localparam int PCW  = $clog2(PIX) + 1;
    localparam int CHW  = $clog2(DSP_NO + 1);
    localparam int IDXW = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    localparam logic [PCW-1:0] PIX_FULL = PCW'(PIX);
    localparam logic [CHW-1:0] CH_END   = CHW'(DSP_NO);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_q;
    logic [CHW-1:0]      ch_q;
    logic [AW-1:0]       base_q;
    logic [AW-1:0]       addr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                we_q;
    logic                fb_q;
    logic                done_q;
    logic                ovr_q;
    logic [PCW-1:0]      pix_q;
    logic [WIDTH-1:0]    shadow_q [0:DSP_NO-1];

    logic                accept;
    logic [IDXW-1:0]     ch_idx;

    // A sample is taken only in IDLE, while the image is incomplete and not being re-armed.
    assign accept = (state_q == IDLE) && !clear && sample_in && (pix_q != PIX_FULL);
    // ch_q runs 1..DSP_NO in WRITE; channel 0 is issued directly from ofm_in on capture.
    assign ch_idx = ch_q[IDXW-1:0];

    // Shadow copy of the vector, held stable while its channels are streamed out.
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow_q <= ofm_in;
        end
    end

    // Control FSM with registered RAM port, handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fb_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pix_q   <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            ch_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            fb_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pix_q   <= '0;
        end else begin
            fb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pix_q == PIX_FULL) begin
                        // Image complete: trailing strobes are ignored, wait for the layer.
                        if (layer_finish) begin
                            fb_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (sample_in) begin
                        we_q    <= 1'b1;
                        wdata_q <= ofm_in[0];
                        addr_q  <= base_q;
                        ch_q    <= CHW'(1);
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (sample_in) begin
                        ovr_q <= 1'b1;
                    end
                    if (ch_q == CH_END) begin
                        we_q    <= 1'b0;
                        base_q  <= base_q + AW'(DSP_NO);
                        pix_q   <= pix_q + PCW'(1);
                        ch_q    <= '0;
                        state_q <= IDLE;
                    end else begin
                        wdata_q <= shadow_q[ch_idx];
                        addr_q  <= addr_q + AW'(1);
                        ch_q    <= ch_q + CHW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_we       = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign ram_feedback = fb_q;
    assign done         = done_q;
    assign overrun      = ovr_q;
    assign pix_count    = pix_q;

endmodule

// File: tb/tb_fire9_squeeze_ofm_writer.sv
// Bench for fire9_squeeze_ofm_writer: scoreboard of expected RAM writes plus scenario tasks.
module tb_fire9_squeeze_ofm_writer;

    localparam int WIDTH  = 16;
    localparam int DSP_NO = 112;
    localparam int WOUT   = 8;
    localparam int AW     = 13;
    localparam int PIX    = WOUT * WOUT;
    localparam int PCW    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_in;
    logic [WIDTH-1:0]  ofm_in [0:DSP_NO-1];
    logic              layer_finish;
    logic              clear;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_feedback;
    logic              done;
    logic              overrun;
    logic [PCW-1:0]    pix_count;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          mon_e;
    int           checks    = 0;
    int           failures  = 0;
    int           wr_cnt    = 0;
    int           fb_cnt    = 0;
    int           model_pix = 0;
    logic [AW-1:0] last_addr = '0;

    fire9_squeeze_ofm_writer #(
        .WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .ofm_in(ofm_in),
        .layer_finish(layer_finish), .clear(clear),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_feedback(ram_feedback), .done(done), .overrun(overrun),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] gen(input int seed, input int c);
        return WIDTH'((seed * 256 + c) ^ ((seed >> 1) * 'h1111));
    endfunction

    // Scoreboard: every RAM write must match the next expected address/data.
    always @(negedge clk) begin
        if (!rst && ram_feedback) fb_cnt++;
        if (!rst && ram_we) begin
            wr_cnt++;
            last_addr = ram_addr;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h required no write", ram_addr, ram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL ram_write got addr=%0d data=%h required addr=%0d data=%h",
                             ram_addr, ram_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One-cycle sample strobe; accepted vectors push their writes to the scoreboard.
    task automatic send(input int seed, input bit accept);
        wr_t e;
        for (int c = 0; c < DSP_NO; c++) ofm_in[c] = gen(seed, c);
        sample_in = 1'b1;
        if (accept) begin
            for (int c = 0; c < DSP_NO; c++) begin
                e.addr = AW'(model_pix * DSP_NO + c);
                e.data = gen(seed, c);
                exp_q.push_back(e);
            end
            model_pix++;
        end
        step(1);
        sample_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        model_pix = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if ({ram_we, ram_feedback, done, overrun} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000", {ram_we, ram_feedback, done, overrun});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0) begin
            failures++;
            $display("FAIL reset_ram got addr=%0d data=%h required 0/0", ram_addr, ram_wdata);
        end
        checks++;
        if (pix_count !== '0) begin
            failures++;
            $display("FAIL reset_pix got=%0d required=0", pix_count);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single_pixel();
        int w0;
        w0 = wr_cnt;
        model_pix = 0;
        send(1, 1'b1);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(0)) begin
            failures++;
            $display("FAIL first_write got we=%b addr=%0d required we=1 addr=0", ram_we, ram_addr);
        end
        step(111);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(111)) begin
            failures++;
            $display("FAIL last_write got we=%b addr=%0d required we=1 addr=111", ram_we, ram_addr);
        end
        step(1);
        checks++;
        if (ram_we !== 1'b0 || pix_count !== PCW'(1)) begin
            failures++;
            $display("FAIL single_end got we=%b pix=%0d required we=0 pix=1", ram_we, pix_count);
        end
        checks++;
        if (wr_cnt - w0 !== 112 || exp_q.size() !== 0 || fb_cnt !== 0) begin
            failures++;
            $display("FAIL single_counts got writes=%0d pending=%0d fb=%0d required 112/0/0",
                     wr_cnt - w0, exp_q.size(), fb_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        send(2, 1'b1);
        step(40);
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_we, ram_feedback, done, overrun} !== 4'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            failures++;
            $display("FAIL abort_outputs got we=%b addr=%0d data=%h required all 0", ram_we, ram_addr, ram_wdata);
        end
        exp_q.delete();
        model_pix = 0;
        step(1);
        rst = 1'b0;
        step(1);
        checks++;
        if (pix_count !== '0) begin
            failures++;
            $display("FAIL abort_pix got=%0d required=0", pix_count);
        end
        send(3, 1'b1);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(0)) begin
            failures++;
            $display("FAIL abort_restart got we=%b addr=%0d required we=1 addr=0", ram_we, ram_addr);
        end
        step(112);
        checks++;
        if (pix_count !== PCW'(1) || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_done got pix=%0d pending=%0d required 1/0", pix_count, exp_q.size());
        end
    endtask

    task automatic test_overrun();
        do_clear();
        checks++;
        if (pix_count !== '0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear got pix=%0d ovr=%b required 0/0", pix_count, overrun);
        end
        send(4, 1'b1);
        step(48);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_early got=%b required=0", overrun);
        end
        send(5, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set got=%b required=1", overrun);
        end
        step(63);
        checks++;
        if (pix_count !== PCW'(1) || overrun !== 1'b1 || ram_we !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL ovr_end got pix=%0d ovr=%b we=%b pending=%0d required 1/1/0/0",
                     pix_count, overrun, ram_we, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_clear();
        w0 = wr_cnt;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_clear_ovr got=%b required=0", overrun);
        end
        send(6, 1'b1);
        step(112);
        send(7, 1'b1);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(DSP_NO)) begin
            failures++;
            $display("FAIL b2b_second got we=%b addr=%0d required we=1 addr=112", ram_we, ram_addr);
        end
        step(112);
        checks++;
        if (pix_count !== PCW'(2) || overrun !== 1'b0 || wr_cnt - w0 !== 224 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_end got pix=%0d ovr=%b writes=%0d pending=%0d required 2/0/224/0",
                     pix_count, overrun, wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_full_image();
        int w0;
        int f0;
        layer_finish = 1'b0;
        do_clear();
        w0 = wr_cnt;
        f0 = fb_cnt;
        for (int p = 0; p < PIX; p++) begin
            send(10 + p, 1'b1);
            step(512);
        end
        send(99, 1'b0);
        step(120);
        checks++;
        if (wr_cnt - w0 !== PIX * DSP_NO || last_addr !== AW'(7167)) begin
            failures++;
            $display("FAIL full_writes got writes=%0d last=%0d required 7168/7167", wr_cnt - w0, last_addr);
        end
        checks++;
        if (pix_count !== PCW'(PIX) || overrun !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL full_state got pix=%0d ovr=%b pending=%0d required 64/0/0",
                     pix_count, overrun, exp_q.size());
        end
        checks++;
        if (fb_cnt !== f0 || done !== 1'b0) begin
            failures++;
            $display("FAIL full_no_finish got fb=%0d done=%b required %0d/0", fb_cnt, done, f0);
        end
    endtask

    task automatic test_late_finish();
        int w0;
        int f0;
        w0 = wr_cnt;
        f0 = fb_cnt;
        step(200);
        layer_finish = 1'b1;
        step(1);
        checks++;
        if (ram_feedback !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL fb_pulse got fb=%b done=%b required 1/0", ram_feedback, done);
        end
        step(1);
        checks++;
        if (ram_feedback !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_rise got fb=%b done=%b required 0/1", ram_feedback, done);
        end
        send(100, 1'b0);
        step(120);
        checks++;
        if (wr_cnt !== w0 || done !== 1'b1 || fb_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL done_hold got writes=%0d done=%b pulses=%0d required 0/1/1",
                     wr_cnt - w0, done, fb_cnt - f0);
        end
    endtask

    task automatic test_clear_collision();
        int w0;
        w0 = wr_cnt;
        clear = 1'b1;
        send(101, 1'b0);
        clear = 1'b0;
        layer_finish = 1'b0;
        checks++;
        if (done !== 1'b0 || pix_count !== '0 || overrun !== 1'b0 || ram_feedback !== 1'b0) begin
            failures++;
            $display("FAIL clr_state got done=%b pix=%0d ovr=%b fb=%b required 0/0/0/0",
                     done, pix_count, overrun, ram_feedback);
        end
        step(5);
        checks++;
        if (wr_cnt !== w0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL clr_nocapture got writes=%0d we=%b required 0/0", wr_cnt - w0, ram_we);
        end
        model_pix = 0;
        send(102, 1'b1);
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(0)) begin
            failures++;
            $display("FAIL clr_restart got we=%b addr=%0d required we=1 addr=0", ram_we, ram_addr);
        end
        step(112);
        checks++;
        if (pix_count !== PCW'(1) || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL clr_end got pix=%0d pending=%0d required 1/0", pix_count, exp_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        sample_in    = 1'b0;
        layer_finish = 1'b0;
        clear        = 1'b0;
        for (int c = 0; c < DSP_NO; c++) ofm_in[c] = '0;
        test_reset();
        test_single_pixel();
        test_reset_mid_write();
        test_overrun();
        test_back_to_back();
        test_full_image();
        test_late_finish();
        test_clear_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fire9_squeeze_ofm_writer.md
# fire9_squeeze_ofm_writer

Receive-side companion of the fire9 squeeze layer. Captures each parallel output vector (`DSP_NO` channels) on the layer's sample strobe and serializes it into the feature-map RAM, one word per cycle, in pixel-major/channel-minor order. Once all `WOUT**2` pixels are written and the layer reports finish, it returns a one-cycle `ram_feedback` pulse to the layer, closing the handshake. It then holds `done` for the downstream expand stage.

## Interface
Parameters:
- `WIDTH`, 16, word width of each channel value and RAM word.
- `DSP_NO`, 112, channels per sample vector.
- `WOUT`, 8, output feature-map side; pixels per layer = `WOUT**2`.
- `AW`, `$clog2(WOUT**2*DSP_NO)`, RAM address width (13 with defaults).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset; asynchronous and active-high.
- `sample_in`  in  1  layer sample strobe; `ofm_in` is valid in the same cycle.
- `ofm_in`  in  `WIDTH` x `DSP_NO` (unpacked `[0:DSP_NO-1]`)  layer output vector.
- `layer_finish`  in  1  layer finish level.
- `clear`  in  1  synchronous re-arm for the next image.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  `AW`  RAM write address.
- `ram_wdata`  out  `WIDTH`  RAM write data.
- `ram_feedback`  out  1  one-cycle pulse to the layer.
- `done`  out  1  all pixels stored and handshake complete.
- `overrun`  out  1  sticky flag: a sample was dropped.
- `pix_count`  out  `$clog2(WOUT**2)+1`  pixels accepted so far.

## Operation
States: IDLE, WRITE, DONE.

- **IDLE**
  - If `sample_in=1` and `pix_count<WOUT**2`: copy all of `ofm_in` into the shadow register, set `ch=0`, go to WRITE.
  - If `sample_in=1` and `pix_count==WOUT**2`: ignore the sample. No write, no flag. This tolerates the layer's trailing extra strobe.
  - If `pix_count==WOUT**2` and `layer_finish=1`: pulse `ram_feedback` for one cycle, go to DONE.
- **WRITE**
  - Each cycle: `ram_we=1`, `ram_wdata=shadow[ch]`, `ram_addr=base+ch`.
  - When `ch==DSP_NO-1`: `base<=base+DSP_NO`, `pix_count<=pix_count+1`, go to IDLE.
  - Address is a running counter (no multiplier): pixel p, channel c maps to `p*DSP_NO+c`.
- **DONE**
  - `done=1`. All `sample_in` are ignored. Stays in DONE until `clear` or `rst`.

Additional rules:
- A `sample_in=1` while in WRITE sets `overrun` (sticky) and the sample is dropped. The in-flight vector completes unchanged.
- `clear=1` from any state: go to IDLE; `pix_count`, `base`, `ch`, `overrun` and `done` go to 0; `ram_we` goes to 0 on the next cycle.
  - `clear` wins over a same-cycle `sample_in`, which is not captured.
- `rst` mid-WRITE aborts immediately. The partial pixel is lost and `pix_count` is not incremented.
- No arithmetic on data: words pass through bit-exact (the layer has already applied ReLU and truncation).

## Timing
- Reset values: state IDLE; `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `ram_feedback=0`, `done=0`, `overrun=0`, `pix_count=0`.
- All outputs are registered.
- Write timing: for a sample accepted in cycle t, channel k is written in cycle t+1+k. The last write is in cycle t+`DSP_NO`, and the block is back in IDLE in cycle t+`DSP_NO`+1.
- Minimum accepted sample spacing is `DSP_NO`+1 cycles. The layer's native spacing (CHIN+1 = 513) always meets this.
- `pix_count` increments in the cycle after the last write of a pixel.
- Feedback timing:
  - `ram_feedback` is high exactly one cycle: the first IDLE cycle with `pix_count==WOUT**2` and `layer_finish=1`.
  - `done` rises in the following cycle.
  - If `layer_finish` was already high, this is 1 cycle after the return to IDLE.
- `overrun` rises one cycle after the offending `sample_in`.

## Test plan
- **Reset values:** assert `rst` mid-WRITE -> all outputs 0 the same cycle, state IDLE. After release, a new sample writes from `ram_addr=0`.
- **Single pixel:** `ofm_in[c]=c+16'h100`, one `sample_in` -> 112 consecutive writes at addresses 0..111 with data 16'h100..16'h16F. `pix_count=1`, `ram_feedback` stays 0.
- **Full image:** 64 samples spaced 513 cycles apart, then a trailing 65th sample, `layer_finish=1` -> 7168 writes, last at `ram_addr=7167`. The 65th sample is ignored with `overrun=0`. One `ram_feedback` pulse, then `done=1`.
- **Overrun:** second `sample_in` 50 cycles after the first -> `overrun=1`. The first vector completes intact and `pix_count` ends at 1.
- **Late finish:** 64 pixels stored, `layer_finish` raised 200 cycles later -> `ram_feedback` in the first cycle `layer_finish` is seen, `done` the next cycle.
- **Clear/sample collision:** `clear` and `sample_in` in the same cycle during DONE -> IDLE with all counters 0, nothing captured. The next sample writes from address 0.
